seven_segment_scan_driver: RTL and testbench
============================================

SEVEN_SEGMENT_SCAN_DRIVER -- requirements
Module: seven_segment_scan_driver

Interface
REQ-001 Parameter DATA_W, default 8: width of the binary input value.
REQ-002 Parameter NUM_DIGITS, default 3: number of displayed digits, 1..8.
REQ-003 Parameter NUM_ANODES, default 8: anode vector width; NUM_ANODES >= NUM_DIGITS.
REQ-004 Parameter REFRESH_DIV, default 100000: clk cycles per digit-scan step, >= 2.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous and active-high.
REQ-007 Port bin_in  input  DATA_W  unsigned value to display.
REQ-008 Port load  input  1  single-cycle strobe; captures bin_in when idle.
REQ-009 Port hex_mode  input  1  sampled with load: 1 = hexadecimal, 0 = decimal.
REQ-010 Port blank_lz  input  1  live control: 1 = blank leading zeros.
REQ-011 Port anode  output  NUM_ANODES  active-low digit enables, registered.
REQ-012 Port hex_out  output  7  active-low segments {a,b,c,d,e,f,g}, MSB = a, registered.
REQ-013 Port busy  output  1  high while a conversion is in progress.
REQ-014 Port overflow  output  1  high when the last loaded value did not fit in NUM_DIGITS.

Function
REQ-015 Conversion FSM states: IDLE, SHIFT, COMMIT; busy SHALL be 1 in SHIFT and COMMIT.
REQ-016 IDLE with load=1 SHALL capture bin_in and hex_mode; decimal goes to SHIFT, hex goes directly to COMMIT.
REQ-017 SHIFT SHALL perform one shift-add-3 (double-dabble) step per cycle for exactly DATA_W cycles, then go to COMMIT.
REQ-018 COMMIT SHALL write all display digit registers in one cycle and return to IDLE; displayed digits never show a partial result.
REQ-019 Latency from load edge to updated digit registers: DATA_W+2 cycles in decimal mode, 2 cycles in hex mode.
REQ-020 load asserted outside IDLE SHALL be ignored with no effect on the conversion in progress.
REQ-021 Hex mode: digit i = bin_in nibble i (zero-extended); codes 0-9 as decimal, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-022 Decimal codes: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 Overflow: a nonzero digit beyond position NUM_DIGITS-1 SHALL set overflow=1 in COMMIT, and every digit SHALL show dash 1111110; a fitting value clears overflow.
REQ-024 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; the scan index advances on wrap, NUM_DIGITS-1 -> 0.
REQ-025 anode bit = scan index SHALL be 0; all other bits, including bits >= NUM_DIGITS, SHALL be 1.
REQ-026 hex_out SHALL show the code of the digit selected by the scan index, in the same cycle as anode.
REQ-027 With blank_lz=1 and no overflow, digits above the most significant nonzero digit SHALL show 1111111; digit 0 is never blanked.
REQ-028 Scanning SHALL continue uninterrupted during conversions.

Reset
REQ-029 On rst: state IDLE, busy 0, overflow 0, digit registers 0, refresh counter 0, scan index 0, anode all ones, hex_out 1111111.
REQ-030 rst during SHIFT or COMMIT SHALL abort the conversion; digit registers SHALL return to 0.
REQ-031 The first cycle after rst deassertion SHALL drive anode = ...11111110 with digit 0 = code for 0.

Structure
REQ-032 Package seven_seg_pkg SHALL hold the segment code constants (0-F, dash, blank) and the FSM state enumeration.
REQ-033 The double-dabble datapath SHALL be a sub-module bin2bcd_serial with start, done, and a BCD output of NUM_DIGITS+1 digits.
REQ-034 The top level SHALL contain the FSM, the digit registers, the refresh and scan logic, and the output decode.

Verification (REFRESH_DIV=4, defaults otherwise)
REQ-035 Decimal load bin_in=8'd237 -> busy for 9 cycles; after the scan, digits show 2,3,7 = 0010010, 0000110, 0001111; overflow 0.
REQ-036 Hex load 8'hAF with NUM_DIGITS=3 -> digits F, A, 0 after 2 cycles; with blank_lz=1, digit 2 shows 1111111.
REQ-037 Decimal load 8'd5 with blank_lz=1 -> digit 0 = 0100100; digits 1 and 2 = 1111111; toggling blank_lz to 0 shows 0000001 on the next scan of each digit.
REQ-038 NUM_DIGITS=2, decimal load 8'd150 -> overflow 1, both digits show 1111110; then load 8'd42 -> overflow 0, digits show 4,2.
REQ-039 Load 8'd99, then load 8'd11 three cycles later, then rst on cycle 5 -> second load ignored; after rst, all digits 0, busy 0, anode 11111110.
REQ-040 Free-run 40 cycles -> anode sequence FE, FD, FB, FE, each held exactly 4 cycles; bits 3-7 never low.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver: active-low segment
// codes {a,b,c,d,e,f,g} with a in the MSB, and the conversion FSM states.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    case (d)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      4'hF: s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one shift-add-3 step per clock for DATA_W
// clocks after start. carry_out is sticky for any bit pushed past the top digit.
module bin2bcd_serial #(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [DATA_W-1:0]             bin,
  output logic                          done,
  output logic [4*(NUM_DIGITS+1)-1:0]   bcd,
  output logic                          carry_out
);

  localparam int BCD_W = 4 * (NUM_DIGITS + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              lost_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      lost_q <= 1'b0;
    end else if (start) begin
      sh_q   <= bin;
      bcd_q  <= '0;
      cnt_q  <= CNT_W'(DATA_W);
      lost_q <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q  <= {adj[BCD_W-2:0], sh_q[DATA_W-1]};
      sh_q   <= sh_q << 1;
      lost_q <= lost_q | adj[BCD_W-1];
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // done marks the final step; bcd holds the full result from the next cycle
  assign done      = (cnt_q == CNT_W'(1));
  assign bcd       = bcd_q;
  assign carry_out = lost_q;

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Binary-to-display driver: converts a loaded value to hex or decimal digits
// and time-multiplexes them onto an active-low anode/segment pair.
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int NUM_ANODES  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     bin_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic [NUM_ANODES-1:0] anode,
  output logic [6:0]            hex_out,
  output logic                  busy,
  output logic                  overflow,
  output conv_state_t           state_dbg
);

  localparam int BCD_W  = 4 * (NUM_DIGITS + 1);
  localparam int HEX_N  = (DATA_W + 3) / 4;
  localparam int EXT_W  = 4 * ((HEX_N > NUM_DIGITS) ? HEX_N : NUM_DIGITS);
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW     = $clog2(REFRESH_DIV);

  conv_state_t             state_q, state_d;
  logic [DATA_W-1:0]       val_q;
  logic                    mode_q;
  logic [4*NUM_DIGITS-1:0] dig_q, new_dig;
  logic                    ovf_q, new_ovf;
  logic [EXT_W-1:0]        val_ext;
  logic                    bcd_start, bcd_done, bcd_carry;
  logic [BCD_W-1:0]        bcd;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;
  logic [RW-1:0]           refresh_q;
  logic [SCAN_W-1:0]       scan_q;
  logic [3:0]              cur_dig;
  logic [6:0]              seg_d;
  logic [NUM_ANODES-1:0]   anode_q;
  logic [6:0]              hex_q;

  // Handshake: load is honoured only while busy is low; strobes seen while
  // busy is high are dropped and never disturb the conversion in flight.
  assign bcd_start = (state_q == ST_IDLE) && load && !hex_mode;

  bin2bcd_serial #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk       (clk),
    .rst       (rst),
    .start     (bcd_start),
    .bin       (bin_in),
    .done      (bcd_done),
    .bcd       (bcd),
    .carry_out (bcd_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = hex_mode ? ST_COMMIT : ST_SHIFT;
      ST_SHIFT:  if (bcd_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= '0;
      mode_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && load) begin
      val_q  <= bin_in;
      mode_q <= hex_mode;
    end
  end

  always_comb begin
    val_ext = EXT_W'(val_q);
    if (mode_q) begin
      new_dig = val_ext[4*NUM_DIGITS-1:0];
      new_ovf = |(val_ext >> (4 * NUM_DIGITS));
    end else begin
      new_dig = bcd[4*NUM_DIGITS-1:0];
      new_ovf = (|bcd[BCD_W-1:4*NUM_DIGITS]) | bcd_carry;
    end
  end

  // All digits change together in COMMIT so the scan never shows a mix
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == ST_COMMIT) begin
      dig_q <= new_dig;
      ovf_q <= new_ovf;
    end
  end

  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above & (dig_q[4*i +: 4] == 4'd0);
      blank_mask[i] = blank_lz && !ovf_q && (i != 0) && zero_above;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      scan_q    <= '0;
    end else if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      scan_q    <= (scan_q == SCAN_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  always_comb begin
    cur_dig = dig_q[4*scan_q +: 4];
    if (ovf_q)                   seg_d = SEG_DASH;
    else if (blank_mask[scan_q]) seg_d = SEG_BLANK;
    else                         seg_d = seg_code(cur_dig);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode_q <= '1;
      hex_q   <= SEG_BLANK;
    end else begin
      anode_q <= ~(NUM_ANODES'(1) << scan_q);
      hex_q   <= seg_d;
    end
  end

  assign anode     = anode_q;
  assign hex_out   = hex_q;
  assign busy      = (state_q != ST_IDLE);
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver with a fast refresh: a 3-digit instance
// for the main table and sequences, and a 2-digit instance for overflow.
module tb_seven_segment_scan_driver;
  import seven_seg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] bin_in;
  logic       load, hex_mode, blank_lz;
  logic [7:0] anode;
  logic [6:0] hex_out;
  logic       busy, overflow;
  conv_state_t state_dbg;

  logic [7:0] bin2;
  logic       load2, hex2, blz2;
  logic [7:0] anode2;
  logic [6:0] hex2_out;
  logic       busy2, ovf2;
  conv_state_t state2;

  seven_segment_scan_driver #(
    .DATA_W(8), .NUM_DIGITS(3), .NUM_ANODES(8), .REFRESH_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .bin_in(bin_in), .load(load), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .anode(anode), .hex_out(hex_out), .busy(busy),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  seven_segment_scan_driver #(
    .DATA_W(8), .NUM_DIGITS(2), .NUM_ANODES(8), .REFRESH_DIV(4)
  ) dut2 (
    .clk(clk), .rst(rst), .bin_in(bin2), .load(load2), .hex_mode(hex2),
    .blank_lz(blz2), .anode(anode2), .hex_out(hex2_out), .busy(busy2),
    .overflow(ovf2), .state_dbg(state2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [6:0] exp_q[$];
  logic [6:0] seen  [3];
  logic [6:0] seen2 [2];

  typedef struct {
    logic [7:0] val;
    logic       hx;
    logic       blz;
    logic [6:0] s2, s1, s0;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_load(input logic [7:0] v, input logic hx);
    @(negedge clk);
    bin_in = v; hex_mode = hx; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic collect();
    @(posedge clk);
    for (int i = 0; i < 3; i++) seen[i] = 7'h55;
    repeat (16) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (anode[i] == 1'b0) seen[i] = hex_out;
    end
  endtask

  task automatic push_exp(input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    exp_q.push_back(s0); exp_q.push_back(s1); exp_q.push_back(s2);
  endtask

  task automatic compare_digits(input string name);
    logic [6:0] e;
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s: scoreboard empty at digit %0d", name, i);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s digit%0d", name, i), 32'(seen[i]), 32'(e));
      end
    end
  endtask

  task automatic load2_run(input logic [7:0] v, output int cycles);
    @(negedge clk);
    bin2 = v; hex2 = 1'b0; load2 = 1'b1;
    @(negedge clk);
    load2 = 1'b0;
    cycles = 0;
    while (busy2 === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) seen2[i] = 7'h55;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (anode2[i] == 1'b0) seen2[i] = hex2_out;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int c;
    logic [7:0] exp_an;

    vecs[0]  = '{8'd237, 1'b0, 1'b0, 7'h12, 7'h06, 7'h0F};
    vecs[1]  = '{8'hAF,  1'b1, 1'b0, 7'h01, 7'h08, 7'h38};
    vecs[2]  = '{8'hAF,  1'b1, 1'b1, 7'h7F, 7'h08, 7'h38};
    vecs[3]  = '{8'd255, 1'b0, 1'b0, 7'h12, 7'h24, 7'h24};
    vecs[4]  = '{8'd0,   1'b0, 1'b1, 7'h7F, 7'h7F, 7'h01};
    vecs[5]  = '{8'h3C,  1'b1, 1'b0, 7'h01, 7'h06, 7'h31};
    vecs[6]  = '{8'hDE,  1'b1, 1'b0, 7'h01, 7'h42, 7'h30};
    vecs[7]  = '{8'd100, 1'b0, 1'b1, 7'h4F, 7'h01, 7'h01};
    vecs[8]  = '{8'h0B,  1'b1, 1'b1, 7'h7F, 7'h7F, 7'h60};
    vecs[9]  = '{8'd69,  1'b0, 1'b1, 7'h7F, 7'h20, 7'h04};
    vecs[10] = '{8'd8,   1'b0, 1'b0, 7'h01, 7'h01, 7'h00};
    vecs[11] = '{8'd5,   1'b0, 1'b1, 7'h7F, 7'h7F, 7'h24};

    rst = 1'b1;
    bin_in = '0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
    bin2 = '0; load2 = 1'b0; hex2 = 1'b0; blz2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset anode", 32'(anode), 32'hFF);
    check("reset hex_out", 32'(hex_out), 32'h7F);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("first anode", 32'(anode), 32'hFE);
    check("first hex_out", 32'(hex_out), 32'h01);

    // table-driven conversions
    for (int v = 0; v < 12; v++) begin
      blank_lz = vecs[v].blz;
      do_load(vecs[v].val, vecs[v].hx);
      wait_busy(c);
      check($sformatf("vec%0d busy cycles", v), 32'(c), vecs[v].hx ? 32'd1 : 32'd9);
      check($sformatf("vec%0d overflow", v), 32'(overflow), 32'd0);
      push_exp(vecs[v].s2, vecs[v].s1, vecs[v].s0);
      collect();
      compare_digits($sformatf("vec%0d", v));
    end

    // live blank_lz toggle on the value 5 left by the last vector
    @(negedge clk);
    blank_lz = 1'b0;
    push_exp(7'h01, 7'h01, 7'h24);
    collect();
    compare_digits("blank_lz off");

    // load during SHIFT is ignored; result is still 099
    do_load(8'd99, 1'b0);
    repeat (2) @(negedge clk);
    bin_in = 8'd11; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("ignored load state", 32'(state_dbg), 32'(ST_SHIFT));
    wait_busy(c);
    check("ignored load done", 32'(busy), 32'd0);
    push_exp(7'h01, 7'h04, 7'h04);
    collect();
    compare_digits("ignored load");

    // load 99, load 11 three cycles later, rst on cycle 5
    do_load(8'd99, 1'b0);
    repeat (2) @(negedge clk);
    bin_in = 8'd11; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort anode", 32'(anode), 32'hFF);
    check("abort hex_out", 32'(hex_out), 32'h7F);
    @(negedge clk);
    rst = 1'b0;

    // free run after reset: FE, FD, FB each for 4 cycles
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      case (((k - 1) / 4) % 3)
        0:       exp_an = 8'hFE;
        1:       exp_an = 8'hFD;
        default: exp_an = 8'hFB;
      endcase
      check($sformatf("scan k=%0d", k), 32'(anode), 32'(exp_an));
      if (k == 1) check("post-abort digit0", 32'(hex_out), 32'h01);
    end
    check("post-abort busy", 32'(busy), 32'd0);
    check("post-abort overflow", 32'(overflow), 32'd0);
    push_exp(7'h01, 7'h01, 7'h01);
    collect();
    compare_digits("post-abort");

    // two-digit instance: overflow then recovery
    blz2 = 1'b1;
    load2_run(8'd150, c);
    check("nd2 150 busy cycles", 32'(c), 32'd9);
    check("nd2 150 overflow", 32'(ovf2), 32'd1);
    check("nd2 150 digit0", 32'(seen2[0]), 32'h7E);
    check("nd2 150 digit1", 32'(seen2[1]), 32'h7E);
    load2_run(8'd42, c);
    check("nd2 42 overflow", 32'(ovf2), 32'd0);
    check("nd2 42 digit0", 32'(seen2[0]), 32'h12);
    check("nd2 42 digit1", 32'(seen2[1]), 32'h4C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
